a_fifo: RTL and testbench
=========================

# a_fifo

Single-clock synchronous FIFO used as the elastic buffer between a data producer and a consumer inside the PYNQ datapath. Words are enqueued on a write request and dequeued in first-in-first-out order on a read request. Full and empty flags guard both sides. All state lives in one clock domain with one asynchronous, active-low reset.

## Interface
- DATA_WIDTH, 16: word width in bits (codebase `bitLength`).
- ADDR_WIDTH, 4: log2 of depth; depth = 2^ADDR_WIDTH = 16 words.
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
- i_wr  input  1  write request, sampled on the rising edge of i_clk.
- i_wdata  input  DATA_WIDTH  write data, sampled with i_wr.
- o_wfull  output  1  FIFO holds 2^ADDR_WIDTH words.
- i_rd  input  1  read request, sampled on the rising edge of i_clk.
- o_rdata  output  DATA_WIDTH  registered read data.
- o_rempty  output  1  FIFO holds 0 words.

## Operation
- Pointers: wptr and rptr, each ADDR_WIDTH+1 bits in binary. The low ADDR_WIDTH bits address memory. The MSB is a wrap bit.
- Empty condition: wptr == rptr.
- Full condition: low bits are equal and the MSBs differ.
- Write accepted iff i_wr && !o_wfull. On acceptance, mem[wptr] <= i_wdata and wptr increments.
- Read accepted iff i_rd && !o_rempty. On acceptance, o_rdata <= mem[rptr] and rptr increments.
- A read that is not accepted leaves o_rdata unchanged.
- Write while full is dropped silently; memory and pointers are unchanged.
- Read while empty is ignored; o_rdata holds its value.
- Simultaneous i_wr and i_rd: each is judged against the flags as they were before the edge.
  - Both accepted: occupancy is unchanged.
  - Full with both requested: only the read is accepted.
  - Empty with both requested: only the write is accepted.
- A word written on an edge is not readable on that same edge; there is no write-to-read bypass.
- Pointers wrap modulo 2^(ADDR_WIDTH+1).
- Reset (any time, including mid-transfer) asynchronously clears:
  - wptr and rptr to 0;
  - o_rdata to 0;
  - o_rempty to 1 and o_wfull to 0.
- Memory contents are not reset. Any request on the edge where reset is asserted is ignored.

## Timing
- Flags are pure decodes of the pointer registers and change only after a clock edge or reset.
- Write-to-empty latency: a write on edge N deasserts o_rempty after edge N.
  - The word is readable on edge N+1.
  - o_rdata shows it after edge N+1.
- Read latency: i_rd sampled on edge N gives o_rdata valid after edge N (one cycle, registered).
- o_wfull asserts after the edge that accepts the 2^ADDR_WIDTH-th unread word. It deasserts after the next accepted read.
- Occupancy changes by at most ±1 per cycle.
- Reset release: normal operation begins on the first rising edge with i_rst_n = 1.

## Structure
- Shared package `fifo_pkg` holds:
  - DATA_WIDTH and ADDR_WIDTH defaults (mirroring `bitLength`);
  - the derived DEPTH constant.
- Sub-module `fifo_mem`: a simple dual-port register array.
  - One synchronous write port (we, waddr, wdata).
  - One registered read port (re, raddr, rdata, with async reset of rdata).
- Top level `a_fifo` holds the pointers, flag decode and accept logic.

## Test plan
- Reset, then idle -> o_rempty=1, o_wfull=0, o_rdata=0. A read with i_rd=1 leaves o_rdata=0.
- Write 10 then 20; wait 3 cycles; hold i_rd=1 -> o_rdata=10 after the first read edge and 20 after the second. o_rempty=1 after the second read; further reads hold o_rdata=20.
- Write 16 words 0..15 -> o_wfull=1 after the 16th. A 17th write of 99 is dropped. 16 reads return 0..15 in order, then o_rempty=1.
- Wrap-around: repeat fill/drain 3 times with values k*16+i -> data is always in order and the flags stay correct across pointer wrap.
- Simultaneous i_wr/i_rd:
  - At half occupancy, occupancy is constant over 20 cycles and the order is preserved.
  - When empty, write 7 with i_rd=1 -> the read is ignored and o_rempty=0 next cycle.
  - When full, both asserted -> the read is accepted, the write is dropped and o_wfull=0.
- Mid-operation reset: write 10 and 20, pulse i_rst_n low -> o_rempty=1 and o_rdata=0 immediately. Then write 12, 16 and 96; reads return 12, 16, 96.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the a_fifo elastic buffer.
// Defaults mirror the datapath word length.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 16;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array for a_fifo.
// One synchronous write port, one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/a_fifo.sv
// Single-clock synchronous FIFO with full/empty guards.
// Pointers carry a wrap bit to tell full from empty.
module a_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_wfull,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rempty
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_ok;
    logic          w_rd_ok;

    // Flags decode straight from the pointer registers.
    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0])
                && (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]);
        w_wr_ok = i_wr && !w_full;
        w_rd_ok = i_rd && !w_empty;
    end

    assign o_wfull  = w_full;
    assign o_rempty = w_empty;

    // Advance each pointer on an accepted request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (i_wdata),
        .i_re    (w_rd_ok),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (o_rdata)
    );

endmodule

// File: tb/tb_a_fifo.sv
// Self-checking bench for a_fifo.
// Queue-based reference model plus directed and random traffic.
module tb_a_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_wr;
    logic [DW-1:0] i_wdata;
    logic          i_rd;
    logic          o_wfull;
    logic          o_rempty;
    logic [DW-1:0] o_rdata;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rdata;

    a_fifo u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_wr     (i_wr),
        .i_wdata  (i_wdata),
        .o_wfull  (o_wfull),
        .i_rd     (i_rd),
        .o_rdata  (o_rdata),
        .o_rempty (o_rempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".empty"}, 32'(o_rempty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(o_wfull), 32'(q.size() == DEPTH));
        check({tag, ".rdata"}, 32'(o_rdata), 32'(exp_rdata));
    endtask

    // One clock of traffic; model judges requests on pre-edge occupancy.
    task automatic step(input logic wr, input logic [DW-1:0] d,
                        input logic rd, input string tag);
        bit wr_ok;
        bit rd_ok;
        @(negedge clk);
        i_wr    = wr;
        i_wdata = d;
        i_rd    = rd;
        wr_ok   = wr && (q.size() < DEPTH);
        rd_ok   = rd && (q.size() > 0);
        @(posedge clk);
        if (rd_ok) exp_rdata = q.pop_front();
        if (wr_ok) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, tag);
    endtask

    // Asynchronous reset mid-cycle with requests active across an edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        i_wr    = 1'b1;
        i_wdata = 16'hBEEF;
        i_rd    = 1'b1;
        #2 rst_n = 1'b0;
        q.delete();
        exp_rdata = '0;
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
        i_wr  = 1'b0;
        i_rd  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        i_wr      = 1'b0;
        i_wdata   = '0;
        i_rd      = 1'b0;
        exp_rdata = '0;
        do_reset("rst0");

        idle(2, "idle");
        step(1'b0, '0, 1'b1, "rd_empty");

        step(1'b1, 16'd10, 1'b0, "w10");
        step(1'b1, 16'd20, 1'b0, "w20");
        idle(3, "wait");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "rd_pair");

        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, "fill");
        step(1'b1, 16'd99, 1'b0, "w_full_drop");
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, "drain");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++)
                step(1'b1, DW'(k * 16 + i), 1'b0, "wrap_fill");
            for (int i = 0; i < DEPTH; i++)
                step(1'b0, '0, 1'b1, "wrap_drain");
        end

        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, DW'(100 + i), 1'b0, "half");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(200 + i), 1'b1, "both_half");
            check("both_half.occ", 32'(q.size()), 32'(DEPTH / 2));
        end
        for (int i = 0; i < DEPTH / 2; i++) step(1'b0, '0, 1'b1, "half_drain");

        step(1'b1, 16'd7, 1'b1, "both_empty");
        step(1'b0, '0, 1'b1, "rd7");
        check("rd7.val", 32'(o_rdata), 32'd7);

        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(300 + i), 1'b0, "fill2");
        step(1'b1, 16'd555, 1'b1, "both_full");
        check("both_full.occ", 32'(q.size()), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain2");

        step(1'b1, 16'd10, 1'b0, "pre_rst");
        step(1'b1, 16'd20, 1'b0, "pre_rst");
        do_reset("rst_mid");
        step(1'b1, 16'd12, 1'b0, "post_w");
        step(1'b1, 16'd16, 1'b0, "post_w");
        step(1'b1, 16'd96, 1'b0, "post_w");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "post_r");
        check("post_r.last", 32'(o_rdata), 32'd96);

        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 9) < 3 + 2 * bias),
                 DW'($urandom),
                 ($urandom_range(0, 9) < 7 - 2 * bias),
                 "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
